// File: rtl/sedge_debounce.sv
// Multi-channel synchroniser + debouncer + selectable edge pulse generator.
// Optional sticky-flag capture per channel is compiled in with SEDGE_STICKY_EN.
module sedge_debounce #(
    parameter int unsigned N_CH        = 4,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned DB_CYCLES   = 4
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic [N_CH-1:0] i_in,
    input  logic [1:0]      i_mode,
`ifdef SEDGE_STICKY_EN
    input  logic [N_CH-1:0] i_clr,
    output logic [N_CH-1:0] o_sticky,
`endif
    output logic [N_CH-1:0] o_level,
    output logic [N_CH-1:0] o_pulse,
    output logic            o_any
);

    localparam int unsigned CNT_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    logic [N_CH-1:0]  sync_q [SYNC_STAGES];
    logic [N_CH-1:0]  s;
    logic [CNT_W-1:0] cnt_q  [N_CH];
    logic [CNT_W-1:0] cnt_d  [N_CH];
    logic [N_CH-1:0]  level_d;
    logic [N_CH-1:0]  pulse_d;
    logic             rise_en;
    logic             fall_en;

    // Synchroniser chain; only the last stage is used downstream
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= i_in;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign s       = sync_q[SYNC_STAGES-1];
    assign rise_en = (i_mode == 2'b00) || (i_mode == 2'b10);
    assign fall_en = (i_mode == 2'b01) || (i_mode == 2'b10);

    // Stability counter per channel; any return to the current level restarts it
    always_comb begin
        level_d = o_level;
        pulse_d = '0;
        for (int unsigned ch = 0; ch < N_CH; ch++) begin
            cnt_d[ch] = '0;
            if (s[ch] != o_level[ch]) begin
                if (cnt_q[ch] == CNT_LAST) begin
                    level_d[ch] = s[ch];
                    pulse_d[ch] = s[ch] ? rise_en : fall_en;
                end else begin
                    cnt_d[ch] = cnt_q[ch] + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int unsigned ch = 0; ch < N_CH; ch++) begin
                cnt_q[ch] <= '0;
            end
            o_level <= '0;
            o_pulse <= '0;
        end else begin
            for (int unsigned ch = 0; ch < N_CH; ch++) begin
                cnt_q[ch] <= cnt_d[ch];
            end
            o_level <= level_d;
            o_pulse <= pulse_d;
        end
    end

    assign o_any = |o_pulse;

`ifdef SEDGE_STICKY_EN
    // Set (from last cycle's pulse) takes priority over clear
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_sticky <= '0;
        end else begin
            o_sticky <= (o_sticky & ~i_clr) | o_pulse;
        end
    end
`endif

endmodule

// File: tb/tb_sedge_debounce.sv
// Scoreboarded bench for sedge_debounce: window-based reference model, directed + random stimulus.
// Build with SEDGE_STICKY_EN defined to also exercise the sticky flags.
module tb_sedge_debounce;

    localparam int unsigned N_CH = 4;
    localparam int unsigned SS   = 2;
    localparam int unsigned DB   = 4;

    logic            i_clk  = 1'b0;
    logic            i_rst  = 1'b1;
    logic [N_CH-1:0] i_in   = '0;
    logic [1:0]      i_mode = 2'b00;
    logic [N_CH-1:0] i_clr  = '0;
    logic [N_CH-1:0] o_level;
    logic [N_CH-1:0] o_pulse;
    logic            o_any;
    logic [N_CH-1:0] o_sticky;

    sedge_debounce #(.N_CH(N_CH), .SYNC_STAGES(SS), .DB_CYCLES(DB)) dut (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_in    (i_in),
        .i_mode  (i_mode),
`ifdef SEDGE_STICKY_EN
        .i_clr   (i_clr),
        .o_sticky(o_sticky),
`endif
        .o_level (o_level),
        .o_pulse (o_pulse),
        .o_any   (o_any)
    );

`ifndef SEDGE_STICKY_EN
    assign o_sticky = '0;
`endif

    always #5 i_clk = ~i_clk;

    typedef struct packed {
        logic [N_CH-1:0] level;
        logic [N_CH-1:0] pulse;
        logic            any;
        logic [N_CH-1:0] sticky;
    } obs_t;

    obs_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    // Reference model: history of raw samples; a level flips once the
    // synchronised value has disagreed with it for DB consecutive edges.
    logic [N_CH-1:0] samp_q[$];
    logic [N_CH-1:0] m_level, m_pulse, m_sticky, m_nl, m_np;
    logic            m_mis;
    obs_t            m_e;

    task automatic model_reset();
        m_level  = '0;
        m_pulse  = '0;
        m_sticky = '0;
        samp_q.delete();
        repeat (SS + DB) samp_q.push_front('0);
    endtask

    always @(posedge i_clk) begin
        if (i_rst) begin
            model_reset();
        end else begin
            m_nl = m_level;
            m_np = '0;
            for (int ch = 0; ch < N_CH; ch++) begin
                m_mis = 1'b1;
                for (int k = 0; k < DB; k++) begin
                    if (samp_q[SS-1+k][ch] == m_level[ch]) m_mis = 1'b0;
                end
                if (m_mis) begin
                    m_nl[ch] = ~m_level[ch];
                    m_np[ch] = m_nl[ch] ? (i_mode == 2'd0 || i_mode == 2'd2)
                                        : (i_mode == 2'd1 || i_mode == 2'd2);
                end
            end
`ifdef SEDGE_STICKY_EN
            m_sticky = (m_sticky & ~i_clr) | m_pulse;
`endif
            m_level = m_nl;
            m_pulse = m_np;
            samp_q.push_front(i_in);
            void'(samp_q.pop_back());
        end
        m_e.level  = m_level;
        m_e.pulse  = m_pulse;
        m_e.any    = |m_pulse;
        m_e.sticky = m_sticky;
        exp_q.push_back(m_e);
    end

    // Monitor: outputs are presented every cycle; compare 1 time unit after the edge
    initial begin
        obs_t e, a;
        forever begin
            @(posedge i_clk);
            #1;
            vectors++;
            a.level  = o_level;
            a.pulse  = o_pulse;
            a.any    = o_any;
            a.sticky = o_sticky;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL scoreboard_empty t=%0t: no expected entry for observed %h", $time, a);
            end else begin
                e = exp_q.pop_front();
                if (a !== e) begin
                    miscompares++;
                    $display("FAIL cycle_check t=%0t: got level=%b pulse=%b any=%b sticky=%b, expected level=%b pulse=%b any=%b sticky=%b",
                             $time, a.level, a.pulse, a.any, a.sticky,
                             e.level, e.pulse, e.any, e.sticky);
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge i_clk);
    endtask

    // Assert reset between edges and confirm the outputs clear without a clock
    task automatic async_reset(input int hold);
        i_rst = 1'b1;
        #1;
        vectors++;
        if (o_level !== '0 || o_pulse !== '0 || o_any !== 1'b0 || o_sticky !== '0) begin
            miscompares++;
            $display("FAIL async_reset t=%0t: got level=%b pulse=%b any=%b sticky=%b, expected all zero",
                     $time, o_level, o_pulse, o_any, o_sticky);
        end
        step(hold);
        i_rst = 1'b0;
    endtask

    initial begin
        int seen;
        step(3);
        i_rst = 1'b0;
        step(2);

        // Rising-only mode on ch0: pulse on rise, none on fall
        i_mode = 2'b00;
        i_in[0] = 1'b1; step(20);
        i_in[0] = 1'b0; step(20);

        // Both-edge mode on ch1
        i_mode = 2'b10;
        i_in[1] = 1'b1; step(10);
        i_in[1] = 1'b0; step(20);

        // Glitch shorter than DB, then exactly DB
        i_mode = 2'b00;
        i_in[2] = 1'b1; step(3);
        i_in[2] = 1'b0; step(12);
        i_in[2] = 1'b1; step(4);
        i_in[2] = 1'b0; step(12);

        // Simultaneous ch0/ch3, then with detection off
        i_in = 4'b1001; step(10);
        i_in = 4'b0000; step(10);
        i_mode = 2'b11;
        i_in = 4'b1001; step(10);
        i_in = 4'b0000; step(10);

        // Reset mid-debounce, release with all inputs high
        i_mode = 2'b00;
        i_in = 4'b1111; step(4);
        async_reset(2);
        step(12);
        i_in = 4'b0000; step(12);

        // Sticky: clear coincident with a new set, then a lone clear
        i_mode = 2'b10;
        i_in[0] = 1'b1; step(12);
        i_in[0] = 1'b0;
        seen = 0;
        for (int c = 0; c < 40 && seen == 0; c++) begin
            step(1);
            if (o_pulse[0]) seen = 1;
        end
        if (seen == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL pulse_timeout: no falling pulse on ch0 within 40 cycles, expected one");
        end
        i_clr[0] = 1'b1; step(1);
        i_clr[0] = 1'b0; step(5);
        i_clr[0] = 1'b1; step(1);
        i_clr[0] = 1'b0; step(5);

        // Random phase
        for (int it = 0; it < 300; it++) begin
            i_in  = i_in ^ N_CH'($urandom_range(0, (1 << N_CH) - 1) & $urandom_range(0, (1 << N_CH) - 1));
            i_clr = N_CH'($urandom_range(0, (1 << N_CH) - 1) & $urandom_range(0, (1 << N_CH) - 1)
                          & $urandom_range(0, (1 << N_CH) - 1));
            if ($urandom_range(0, 9) == 0) i_mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 39) == 0) begin
                async_reset(int'($urandom_range(1, 3)));
            end
            step(int'($urandom_range(1, 7)));
        end

        i_in = '0;
        i_clr = '0;
        step(20);
        if (exp_q.size() > 1) begin
            vectors++;
            miscompares++;
            $display("FAIL scoreboard_drain: %0d entries left, expected at most 1", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
